// File: rtl/fft_r22sdf_bfii_pkg.sv
// Shared sizing helpers for the R2^2 SDF stage blocks (BFI, BFII, twiddle).
package fft_r22sdf_bfii_pkg;

  localparam int unsigned DefDw = 24;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Stage counter spans one 4L block.
  function automatic int unsigned ctr_width(input int unsigned fsr_len);
    return clog2(fsr_len) + 2;
  endfunction

endpackage

// File: rtl/fft_r22sdf_ctr.sv
// Valid-gated stage sample counter with start resync; decodes the BFII s/t controls.
module fft_r22sdf_ctr
  import fft_r22sdf_bfii_pkg::*;
#(
  parameter int unsigned FSR_LEN = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  input  logic start_i,
  output logic s_o,
  output logic t_o
);

  localparam int unsigned CW = ctr_width(FSR_LEN);

  logic [CW-1:0] r_c;
  logic [CW-1:0] w_c_cur;

  // A start sample is index 0 regardless of where the count was.
  always_comb begin
    w_c_cur = start_i ? '0 : r_c;
    s_o     = w_c_cur[CW-2];
    t_o     = w_c_cur[CW-1] & w_c_cur[CW-2];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_c <= '0;
    end else if (valid_i) begin
      r_c <= w_c_cur + CW'(1);
    end
  end

endmodule

// File: rtl/fft_r22sdf_bfii.sv
// Radix-2^2 SDF butterfly type II: trivial -j rotation plus radix-2 butterfly over an
// L-deep feedback shift register, registered output.
module fft_r22sdf_bfii
  import fft_r22sdf_bfii_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned FSR_LEN = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          valid_i,
  input  logic          start_i,
  input  logic [DW-1:0] x_re_i,
  input  logic [DW-1:0] x_im_i,
  output logic          valid_o,
  output logic [DW-1:0] z_re_o,
  output logic [DW-1:0] z_im_o
);

  localparam int unsigned PW = clog2(FSR_LEN) + 1;

  logic          w_s;
  logic          w_t;
  logic [DW-1:0] w_xr, w_xi;
  logic [DW-1:0] w_f_re, w_f_im;
  logic [DW-1:0] w_y_re, w_y_im;
  logic [DW-1:0] w_fin_re, w_fin_im;

  logic [DW-1:0] r_fsr_re [FSR_LEN];
  logic [DW-1:0] r_fsr_im [FSR_LEN];
  logic [DW-1:0] r_z_re, r_z_im;
  logic          r_valid;
  logic          r_primed;
  logic [PW-1:0] r_pcnt;

  fft_r22sdf_ctr #(
    .FSR_LEN (FSR_LEN)
  ) u_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .start_i (start_i),
    .s_o     (w_s),
    .t_o     (w_t)
  );

  // All sums are plain DW-bit wraparound; upstream scaling keeps them in range.
  always_comb begin
    w_xr     = w_t ? x_im_i : x_re_i;
    w_xi     = w_t ? (-x_re_i) : x_im_i;
    w_f_re   = r_fsr_re[FSR_LEN-1];
    w_f_im   = r_fsr_im[FSR_LEN-1];
    w_y_re   = w_s ? (w_f_re + w_xr) : w_f_re;
    w_y_im   = w_s ? (w_f_im + w_xi) : w_f_im;
    w_fin_re = w_s ? (w_f_re - w_xr) : w_xr;
    w_fin_im = w_s ? (w_f_im - w_xi) : w_xi;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(FSR_LEN); i++) begin
        r_fsr_re[i] <= '0;
        r_fsr_im[i] <= '0;
      end
      r_z_re <= '0;
      r_z_im <= '0;
    end else if (valid_i) begin
      r_fsr_re[0] <= w_fin_re;
      r_fsr_im[0] <= w_fin_im;
      for (int i = 1; i < int'(FSR_LEN); i++) begin
        r_fsr_re[i] <= r_fsr_re[i-1];
        r_fsr_im[i] <= r_fsr_im[i-1];
      end
      r_z_re <= w_y_re;
      r_z_im <= w_y_im;
    end
  end

  // The first L outputs only flush the empty FSR, so they are never flagged valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid  <= 1'b0;
      r_primed <= 1'b0;
      r_pcnt   <= '0;
    end else begin
      r_valid <= valid_i & r_primed;
      if (valid_i && !r_primed) begin
        if (r_pcnt == PW'(FSR_LEN - 1)) begin
          r_primed <= 1'b1;
        end else begin
          r_pcnt <= r_pcnt + PW'(1);
        end
      end
    end
  end

  assign valid_o = r_valid;
  assign z_re_o  = r_z_re;
  assign z_im_o  = r_z_im;

endmodule

// File: tb/tb_fft_r22sdf_bfii.sv
// Directed bench for fft_r22sdf_bfii: one L=1 and one L=2 instance on shared stimulus.
module tb_fft_r22sdf_bfii;

  localparam int unsigned DW = 24;
  localparam longint MaxPos = (64'sd1 <<< (DW - 1)) - 1;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          start;
  logic [DW-1:0] x_re, x_im;
  logic          v1, v2;
  logic [DW-1:0] re1, im1, re2, im2;

  int checks = 0;
  int errors = 0;

  fft_r22sdf_bfii #(.DW(DW), .FSR_LEN(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .start_i(start),
    .x_re_i(x_re), .x_im_i(x_im), .valid_o(v1), .z_re_o(re1), .z_im_o(im1)
  );

  fft_r22sdf_bfii #(.DW(DW), .FSR_LEN(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .start_i(start),
    .x_re_i(x_re), .x_im_i(x_im), .valid_o(v2), .z_re_o(re2), .z_im_o(im2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic ev, input longint er, input longint ei);
    chk({tag, ".v"}, 64'(v1), 64'(ev));
    if (ev) begin
      chk({tag, ".re"}, 64'($signed(re1)), er);
      chk({tag, ".im"}, 64'($signed(im1)), ei);
    end
  endtask

  task automatic chk2(input string tag, input logic ev, input longint er, input longint ei);
    chk({tag, ".v"}, 64'(v2), 64'(ev));
    if (ev) begin
      chk({tag, ".re"}, 64'($signed(re2)), er);
      chk({tag, ".im"}, 64'($signed(im2)), ei);
    end
  endtask

  task automatic step(input logic v, input logic s, input longint re, input longint im);
    valid = v;
    start = s;
    x_re  = re[DW-1:0];
    x_im  = im[DW-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    start = 1'b0;
    x_re  = '0;
    x_im  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.v1", 64'(v1), 64'd0);
    chk("rst.re1", 64'($signed(re1)), 64'sd0);
    chk("rst.v2", 64'(v2), 64'd0);
    chk("rst.im2", 64'($signed(im2)), 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // L=2: inputs 1..8 then two zeros of the next block flush the FSR.
  longint in2    [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
  longint exp_re [10] = '{0, 0, 4, 6, -2, -2, 5, 6, 5, 6};
  longint exp_im [10] = '{0, 0, 0, 0, 0, 0, -7, -8, 7, 8};

  task automatic run_l2(input bit gaps, input string tag);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g < 3 && gaps && $urandom_range(0, 9) < 3; g++) begin
        step(1'b0, 1'b0, 0, 0);
        chk({tag, ".gap.v"}, 64'(v2), 64'd0);
      end
      step(1'b1, k == 0, in2[k], 0);
      chk2($sformatf("%s.k%0d", tag, k), k >= 2, exp_re[k], exp_im[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    start = 1'b0;
    x_re  = '0;
    x_im  = '0;

    // L=1 block order: x0+x1, x0-x1, x2-jx3, x2+jx3.
    do_reset();
    step(1'b1, 1'b1, 1, 0); chk1("t1.k0", 1'b0, 0, 0);
    step(1'b1, 1'b0, 2, 0); chk1("t1.k1", 1'b1, 3, 0);
    step(1'b1, 1'b0, 3, 0); chk1("t1.k2", 1'b1, -1, 0);
    step(1'b1, 1'b0, 4, 0); chk1("t1.k3", 1'b1, 3, -4);
    step(1'b1, 1'b0, 0, 0); chk1("t1.k4", 1'b1, 3, 4);

    run_l2(1'b0, "t2");
    run_l2(1'b1, "t3");

    // Wraparound: max+max -> -2, max-max -> 0.
    do_reset();
    step(1'b1, 1'b1, MaxPos, 0); chk1("t4.k0", 1'b0, 0, 0);
    step(1'b1, 1'b0, MaxPos, 0); chk1("t4.sum", 1'b1, -2, 0);
    step(1'b1, 1'b0, 0, 0);      chk1("t4.diff", 1'b1, 0, 0);

    // Start at c=2: FSR kept (10-20 drains), then the next sample acts as c=1.
    do_reset();
    step(1'b1, 1'b1, 10, 0); chk1("t5.k0", 1'b0, 0, 0);
    step(1'b1, 1'b0, 20, 0); chk1("t5.k1", 1'b1, 30, 0);
    step(1'b1, 1'b1, 5, 0);  chk1("t5.rs0", 1'b1, -10, 0);
    step(1'b1, 1'b0, 7, 0);  chk1("t5.rs1", 1'b1, 12, 0);
    step(1'b1, 1'b0, 1, 0);  chk1("t5.rs2", 1'b1, -2, 0);

    // Async reset mid-block clears outputs without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.async.v", 64'(v1), 64'd0);
    chk("t6.async.re", 64'($signed(re1)), 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 9, 0); chk1("t6.k0", 1'b0, 0, 0);
    step(1'b1, 1'b0, 4, 0); chk1("t6.k1", 1'b1, 13, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
